// File: rtl/cfg_pkg.sv
// Configuration-chain types: writer FSM states and per-neuron stage layout for image building.
package cfg_pkg;
   typedef enum logic [2:0] {IDLE, LOW, HIGH, NEXT, FINISH} cfg_state_e;

   localparam int E_L_IDX           = 0;
   localparam int TAU_MEM_IDX       = 1;
   localparam int V_THRESH_IDX      = 2;
   localparam int TAU_REF_IDX       = 3;
   localparam int PAD_IDX           = 4;
   localparam int FIELDS_PER_NEURON = PAD_IDX + 1;

   // Chain stage (0 = head) holding a given field of a given neuron.
   function automatic int stage_of(input int neuron, input int field);
      return neuron * FIELDS_PER_NEURON + field;
   endfunction
endpackage

// File: rtl/fp.sv
// Fixed-point word definitions shared by the neuron datapath and its configuration chain.
package fp;
   localparam int WORD_LENGTH = 16;
   typedef logic signed [WORD_LENGTH-1:0] fpType;
endpackage

// File: rtl/config_if.sv
// Neuron configuration daisy-chain link: a slow shift clock plus one word of data.
interface config_if;
   import fp::*;
   logic  data_clk;
   fpType data_in;

   modport master (output data_clk, output data_in);
   modport slave  (input data_clk, input data_in);
endinterface

// File: rtl/cfg_clk_gen.sv
// Phase counter for the chain shift clock: strobes phase_end every CLK_DIV cycles while enabled
// and toggles data_clk at each strobe; disabling it parks data_clk low.
module cfg_clk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic phase_end,
   output logic data_clk
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign phase_end = en && (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         cnt      <= '0;
         data_clk <= 1'b0;
      end else if (phase_end) begin
         cnt      <= '0;
         data_clk <= ~data_clk;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/config_chain_writer.sv
// Host-side writer for the neuron configuration chain: buffers one image, shifts it in word 0 first.
// Define CFG_READBACK_EN to add a second pass that checks the words returned at the chain tail.
module config_chain_writer
   import fp::*;
   import cfg_pkg::*;
#(
   parameter  int NUM_NEURONS       = 4,
   parameter  int STAGES_PER_NEURON = 5,
   parameter  int CLK_DIV           = 4,
   localparam int TOTAL             = NUM_NEURONS * STAGES_PER_NEURON,
   localparam int PTR_W             = $clog2(TOTAL + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  fpType            wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic             start,
   output logic             busy,
   output logic             done,
   config_if.master         cfg_out,
   config_if.slave          cfg_ret,
   output logic             rb_error,
   output logic [PTR_W-1:0] rb_err_count
);
   localparam int               IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [PTR_W-1:0] FULL  = PTR_W'(TOTAL);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(TOTAL - 1);

   cfg_state_e       state;
   logic [PTR_W-1:0] wp, sp, sp_nxt;
   fpType            img_buf [TOTAL];
   fpType            data_in_q;
   logic             shifting, phase_end, data_clk_q;

   assign shifting = (state == LOW) || (state == HIGH);
   assign sp_nxt   = sp + 1'b1;

   cfg_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk       (clk),
      .reset     (reset),
      .en        (shifting),
      .phase_end (phase_end),
      .data_clk  (data_clk_q)
   );

   assign cfg_out.data_clk = data_clk_q;
   assign cfg_out.data_in  = data_in_q;

   // Handshake: a word transfers on a clk edge where wr_valid && wr_ready; the host holds wr_data
   // and wr_valid until then. wr_ready is high only while idle with buffer space left.
   assign wr_ready = (state == IDLE) && (wp < FULL);
   assign busy     = (state != IDLE);

`ifdef CFG_READBACK_EN
   logic             second_pass, rb_error_q;
   logic [PTR_W-1:0] rb_cnt_q;
   logic             unused_ret_clk;

   assign rb_error       = rb_error_q;
   assign rb_err_count   = rb_cnt_q;
   assign unused_ret_clk = cfg_ret.data_clk;
`else
   logic unused_ret;

   assign rb_error     = 1'b0;
   assign rb_err_count = '0;
   assign unused_ret   = &{1'b0, cfg_ret.data_clk, cfg_ret.data_in};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wp        <= '0;
         sp        <= '0;
         data_in_q <= '0;
         done      <= 1'b0;
`ifdef CFG_READBACK_EN
         second_pass <= 1'b0;
         rb_error_q  <= 1'b0;
         rb_cnt_q    <= '0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (wr_valid && wr_ready) begin
                  img_buf[wp[IDX_W-1:0]] <= wr_data;
                  wp                     <= wp + 1'b1;
               end
               if (start && (wp == FULL)) begin
                  state     <= LOW;
                  sp        <= '0;
                  data_in_q <= img_buf[0];
`ifdef CFG_READBACK_EN
                  second_pass <= 1'b0;
                  rb_error_q  <= 1'b0;
                  rb_cnt_q    <= '0;
`endif
               end
            end
            LOW: begin
`ifdef CFG_READBACK_EN
               // The tail word is sampled just before the rising edge that would replace it.
               if (phase_end && second_pass && (cfg_ret.data_in != img_buf[sp[IDX_W-1:0]])) begin
                  rb_error_q <= 1'b1;
                  rb_cnt_q   <= rb_cnt_q + 1'b1;
               end
`endif
               if (phase_end) state <= HIGH;
            end
            HIGH: begin
               if (phase_end) state <= NEXT;
            end
            NEXT: begin
               if (sp == LAST) begin
`ifdef CFG_READBACK_EN
                  if (!second_pass) begin
                     second_pass <= 1'b1;
                     sp          <= '0;
                     data_in_q   <= img_buf[0];
                     state       <= LOW;
                  end else begin
                     done  <= 1'b1;
                     state <= FINISH;
                  end
`else
                  done  <= 1'b1;
                  state <= FINISH;
`endif
               end else begin
                  sp        <= sp_nxt;
                  data_in_q <= img_buf[sp_nxt[IDX_W-1:0]];
                  state     <= LOW;
               end
            end
            FINISH: begin
               wp    <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_config_chain_writer.sv
// Directed-plus-random bench for config_chain_writer with a behavioural daisy-chain model on the link.
module tb_config_chain_writer;
   import fp::*;
   import cfg_pkg::*;

   localparam int NN        = 2;
   localparam int SPN       = 5;
   localparam int CD        = 2;
   localparam int TOTAL     = NN * SPN;
   localparam int PTR_W     = $clog2(TOTAL + 1);
`ifdef CFG_READBACK_EN
   localparam int PASSES    = 2;
`else
   localparam int PASSES    = 1;
`endif
   localparam int OP_CYCLES = PASSES * TOTAL * (2 * CD + 1) + 1;

   logic             clk = 1'b0;
   logic             reset;
   fpType            wr_data;
   logic             wr_valid, wr_ready, start, busy, done, rb_error;
   logic [PTR_W-1:0] rb_err_count;

   config_if cfg_out ();
   config_if cfg_ret ();

   always #5 clk = ~clk;

   config_chain_writer #(
      .NUM_NEURONS       (NN),
      .STAGES_PER_NEURON (SPN),
      .CLK_DIV           (CD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .cfg_out      (cfg_out),
      .cfg_ret      (cfg_ret),
      .rb_error     (rb_error),
      .rb_err_count (rb_err_count)
   );

   // Behavioural chain: shifts on each data_clk rise; optional one-off loss of stage 3's word.
   fpType chain [TOTAL];
   int    edges    = 0;
   bit    fault_en = 1'b0;
   int    fault_at = 0;

   always @(posedge cfg_out.data_clk) begin
      for (int s = TOTAL - 1; s > 0; s--) chain[s] = chain[s-1];
      chain[0] = cfg_out.data_in;
      edges++;
      if (fault_en && edges == fault_at) chain[3] = '0;
   end

   assign cfg_ret.data_in  = chain[TOTAL-1];
   assign cfg_ret.data_clk = cfg_out.data_clk;

   // data_in must not move while data_clk is high and must be settled CD cycles before a rise.
   fpType prev_din   = '0;
   logic  prev_clk   = 1'b0;
   int    stable_cnt = 0;
   int    stab_viol  = 0;

   always @(negedge clk) begin
      if (cfg_out.data_in !== prev_din) begin
         if (cfg_out.data_clk) stab_viol++;
         stable_cnt = 0;
      end else begin
         stable_cnt++;
      end
      if (cfg_out.data_clk === 1'b1 && prev_clk === 1'b0 && stable_cnt < CD) stab_viol++;
      prev_din = cfg_out.data_in;
      prev_clk = cfg_out.data_clk;
   end

   // Expected buffer contents and write pointer.
   fpType img_exp [TOTAL];
   int    wp_exp = 0;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic load_words(input int n, input bit seq);
      fpType w;
      int    t;
      for (int i = 0; i < n; i++) begin
         w        = seq ? fpType'(16'h1000 + i) : fpType'($urandom_range(1, 16'hFFFF));
         wr_data  = w;
         wr_valid = 1'b1;
         t        = 0;
         while (!wr_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         if (!wr_ready) check("load_ready", wr_ready, 1'b1);
         @(negedge clk);
         img_exp[wp_exp] = w;
         wp_exp++;
         wr_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wr_valid = 1'b0;
   endtask

   task automatic run_op(output int busy_cyc, output int dones, output int ready_viol);
      busy_cyc   = 0;
      dones      = 0;
      ready_viol = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < OP_CYCLES + 50; c++) begin
         if (!busy) break;
         busy_cyc++;
         if (done) dones++;
         if (wr_ready) ready_viol++;
         @(negedge clk);
      end
      check("op_terminates", busy, 1'b0);
      wp_exp = 0;
   endtask

   task automatic check_image(input string tag);
      int bad = 0;
      for (int s = 0; s < TOTAL; s++)
         if (chain[s] !== img_exp[TOTAL-1-s]) bad++;
      check(tag, bad, 0);
   endtask

   int bc, dn, rv, e0;

   initial begin
      for (int s = 0; s < TOTAL; s++) chain[s] = '0;
      reset = 1'b1; start = 1'b0; wr_valid = 1'b0; wr_data = '0;
      repeat (3) @(negedge clk);
      check("rst_data_clk", cfg_out.data_clk, 1'b0);
      check("rst_data_in", $unsigned(cfg_out.data_in), 0);
      check("rst_wr_ready", wr_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_rb_error", rb_error, 1'b0);
      check("rst_rb_count", rb_err_count, 0);
      reset = 1'b0;
      @(negedge clk);

      // Directed image 0x1000..0x1009.
      load_words(TOTAL, 1'b1);
      e0 = edges;
      run_op(bc, dn, rv);
      check("seq_busy_cycles", bc, OP_CYCLES);
      check("seq_done_pulses", dn, 1);
      check("seq_edges", edges - e0, PASSES * TOTAL);
      check("seq_head_E_l", $unsigned(chain[stage_of(0, E_L_IDX)]), 32'h1009);
      check("seq_tail", $unsigned(chain[TOTAL-1]), 32'h1000);
      check_image("seq_image");
      check("seq_rb_error", rb_error, 1'b0);

      // Start with a partial image is ignored; completing it then works.
      load_words(7, 1'b0);
      e0 = edges; bc = 0; dn = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) begin
         if (busy) bc++;
         if (done) dn++;
         @(negedge clk);
      end
      check("part_busy", bc, 0);
      check("part_done", dn, 0);
      check("part_edges", edges - e0, 0);
      load_words(3, 1'b0);
      e0 = edges;
      run_op(bc, dn, rv);
      check("part_busy_cycles", bc, OP_CYCLES);
      check("part_done_pulses", dn, 1);
      check_image("part_image");

      // wr_valid held high through a shift stalls and is taken into word 0 afterwards.
      load_words(TOTAL, 1'b0);
      wr_data  = fpType'($urandom_range(1, 16'hFFFF));
      wr_valid = 1'b1;
      run_op(bc, dn, rv);
      check("stall_ready_busy", rv, 0);
      check("stall_busy_cycles", bc, OP_CYCLES);
      check_image("stall_image");
      check("stall_ready_after", wr_ready, 1'b1);
      @(negedge clk);
      img_exp[0] = wr_data;
      wp_exp     = 1;
      wr_valid   = 1'b0;
      load_words(TOTAL - 1, 1'b0);
      run_op(bc, dn, rv);
      check("stall_tail_word", $unsigned(chain[TOTAL-1]), $unsigned(img_exp[0]));
      check_image("stall_image2");

      // Reset 23 cycles into a shift aborts it without a done pulse.
      load_words(TOTAL, 1'b0);
      e0 = edges; dn = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (23) begin
         if (done) dn++;
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      if (done) dn++;
      check("abort_data_clk", cfg_out.data_clk, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_wr_ready", wr_ready, 1'b1);
      check("abort_no_done", dn, 0);
      check("abort_partial", (edges - e0 > 0) && (edges - e0 < TOTAL), 1'b1);
      reset  = 1'b0;
      wp_exp = 0;
      @(negedge clk);
      load_words(TOTAL, 1'b0);
      e0 = edges;
      run_op(bc, dn, rv);
      check("after_abort_cycles", bc, OP_CYCLES);
      check("after_abort_edges", edges - e0, PASSES * TOTAL);
      check_image("after_abort_image");

`ifdef CFG_READBACK_EN
      // Readback over a faithful chain.
      load_words(TOTAL, 1'b0);
      run_op(bc, dn, rv);
      check("rb_ok_cycles", bc, OP_CYCLES);
      check("rb_ok_error", rb_error, 1'b0);
      check("rb_ok_count", rb_err_count, 0);

      // Stage 3 loses its word after pass 1: that one returned word must mismatch.
      load_words(TOTAL, 1'b0);
      fault_at = edges + TOTAL;
      fault_en = 1'b1;
      run_op(bc, dn, rv);
      fault_en = 1'b0;
      check("rb_bad_error", rb_error, 1'b1);
      check("rb_bad_count", rb_err_count, (img_exp[TOTAL-1-3] != 0) ? 1 : 0);
      check_image("rb_bad_image");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("rb_sticky_busy", busy, 1'b0);
      check("rb_sticky_error", rb_error, 1'b1);
      load_words(TOTAL, 1'b0);
      run_op(bc, dn, rv);
      check("rb_cleared_error", rb_error, 1'b0);
      check("rb_cleared_count", rb_err_count, 0);
`else
      check("norb_error", rb_error, 1'b0);
      check("norb_count", rb_err_count, 0);
`endif

      check("data_in_stability", stab_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
